// File: rtl/spi_frame_loader.sv
// rtl/spi_frame_loader.sv - Wishbone sequencer copying SPI flash pages into a frame buffer
//
// Purpose: turns one start pulse into a multi-chunk flash-to-framebuffer copy.
// For each chunk it programs the SPI reader (page index, length, start), polls
// the reader's busy bit, then drains the reader buffer word by word into a
// simple write port.
//
// Optional feature: define SPI_FRAME_LOADER_CHECKSUM_EN to add checksum_o, a
// 32-bit wrapping sum of every word transferred on the sink port.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   start_i, page_i, words_i,
//   out_base_i                      job request, sampled only when idle
//   busy_o, done_o, err_o           status: done_o one-cycle pulse, err_o sticky timeout
//   m_adr_o .. m_cti_o, m_dat_i,
//   m_ack_i                         Wishbone classic single-cycle master
//   out_adr_o, out_dat_o, out_we_o,
//   out_ready_i                     sink write port (transfer when we & ready)
//   checksum_o                      checksum build only

`ifndef SPIMEM_CONTROL
`define SPIMEM_CONTROL 16'h0000
`endif
`ifndef SPIMEM_READ_ADDR
`define SPIMEM_READ_ADDR 16'h0001
`endif
`ifndef SPIMEM_READ_LENGTH
`define SPIMEM_READ_LENGTH 16'h0002
`endif

module spi_frame_loader #(
  parameter logic [15:0] SPI_BASE     = 16'h0000,
  parameter logic [15:0] SPI_MEM_BASE = 16'h1000,
  parameter int          CHUNK_WORDS  = 16,
  parameter int          OUT_AW       = 10,
  parameter int          TIMEOUT      = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       page_i,
  input  logic [15:0]       words_i,
  input  logic [OUT_AW-1:0] out_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       m_adr_o,
  output logic [31:0]       m_dat_o,
  input  logic [31:0]       m_dat_i,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic              m_stb_o,
  output logic              m_cyc_o,
  input  logic              m_ack_i,
  output logic [2:0]        m_cti_o,
  output logic [OUT_AW-1:0] out_adr_o,
  output logic [31:0]       out_dat_o,
  output logic              out_we_o,
  input  logic              out_ready_i
`ifdef SPI_FRAME_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_ADDR, S_SET_LEN, S_KICK, S_POLL, S_FETCH, S_PUSH, S_DONE
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   A_CTL    = SPI_BASE + `SPIMEM_CONTROL;
  localparam logic [15:0]   A_RA     = SPI_BASE + `SPIMEM_READ_ADDR;
  localparam logic [15:0]   A_RL     = SPI_BASE + `SPIMEM_READ_LENGTH;

  state_t            r_state;
  logic [15:0]       r_page, r_remaining, r_n, r_i;
  logic [TW-1:0]     r_tmo;
  logic              r_busy, r_done, r_err, r_cyc, r_we, r_out_we;
  logic [15:0]       r_adr;
  logic [31:0]       r_dat, r_out_dat;
  logic [OUT_AW-1:0] r_out_adr;
  logic [15:0]       w_n;
  logic              w_ack;

  assign w_n   = (r_remaining > 16'(CHUNK_WORDS)) ? 16'(CHUNK_WORDS) : r_remaining;
  assign w_ack = r_cyc & m_ack_i;

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign m_adr_o   = r_adr;
  assign m_dat_o   = r_dat;
  assign m_we_o    = r_we;
  assign m_sel_o   = 4'hF;
  assign m_cti_o   = 3'b000;
  // cyc and stb always move together for single classic cycles
  assign m_cyc_o   = r_cyc;
  assign m_stb_o   = r_cyc;
  assign out_adr_o = r_out_adr;
  assign out_dat_o = r_out_dat;
  assign out_we_o  = r_out_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_page      <= '0;
      r_remaining <= '0;
      r_n         <= '0;
      r_i         <= '0;
      r_tmo       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_out_we    <= 1'b0;
      r_out_dat   <= '0;
      r_out_adr   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_page      <= page_i;
            r_remaining <= words_i;
            r_out_adr   <= out_base_i;
            r_err       <= 1'b0;
            r_tmo       <= '0;
            r_i         <= '0;
            if (words_i == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_SET_ADDR;
            end
          end
        end

        S_SET_ADDR, S_SET_LEN, S_KICK, S_POLL, S_FETCH: begin
          if (w_ack) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_tmo <= '0;
            case (r_state)
              S_SET_ADDR: r_state <= S_SET_LEN;
              S_SET_LEN:  r_state <= S_KICK;
              S_KICK:     r_state <= S_POLL;
              S_POLL: begin
                if (!m_dat_i[0]) begin
                  r_i     <= '0;
                  r_state <= S_FETCH;
                end else begin
                  // the poll budget spans the whole busy-wait, so keep counting
                  r_tmo <= r_tmo + 1'b1;
                end
              end
              S_FETCH: begin
                r_out_dat <= m_dat_i;
                r_out_we  <= 1'b1;
                r_state   <= S_PUSH;
              end
              default: ;
            endcase
          end else if (r_tmo >= TMO_LAST) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (!r_cyc) begin
            // launch; the ack wait counter restarts except inside a poll sequence
            r_cyc <= 1'b1;
            r_tmo <= (r_state == S_POLL) ? r_tmo + 1'b1 : '0;
            case (r_state)
              S_SET_ADDR: begin
                r_adr <= A_RA;
                r_dat <= {16'h0000, r_page};
                r_we  <= 1'b1;
              end
              S_SET_LEN: begin
                r_adr <= A_RL;
                r_dat <= {16'h0000, w_n};
                r_we  <= 1'b1;
                r_n   <= w_n;
              end
              S_KICK: begin
                r_adr <= A_CTL;
                r_dat <= 32'd1;
                r_we  <= 1'b1;
              end
              S_POLL: begin
                r_adr <= A_CTL;
                r_dat <= '0;
                r_we  <= 1'b0;
              end
              default: begin
                r_adr <= SPI_MEM_BASE + r_i;
                r_dat <= '0;
                r_we  <= 1'b0;
              end
            endcase
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_PUSH: begin
          if (out_ready_i) begin
            r_out_we  <= 1'b0;
            r_out_adr <= r_out_adr + 1'b1;
            if (r_i + 16'd1 == r_n) begin
              r_remaining <= r_remaining - r_n;
              r_page      <= r_page + 16'd1;
              if (r_remaining == r_n) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_state <= S_SET_ADDR;
              end
            end else begin
              r_i     <= r_i + 16'd1;
              r_state <= S_FETCH;
            end
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_FRAME_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;

  assign checksum_o = r_csum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_csum <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_csum <= '0;
    end else if (r_state == S_PUSH && r_out_we && out_ready_i) begin
      r_csum <= r_csum + r_out_dat;
    end
  end
`endif

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Wishbone master sequencer that sits directly upstream of the SPI flash reader block and drives its register and buffer interfaces.
- Per chunk it programs a flash page index, length and start, polls busy, then drains the read buffer word by word.
- Drained words go to a simple write port, typically the LED frame buffer.
- Turns one start pulse into a multi-chunk flash-to-framebuffer copy.

Parameters:
- SPI_BASE, 16'h0000, word address of the SPI reader register bank; register offsets come from the SPIMEM_* defines in globals.vh.
- SPI_MEM_BASE, 16'h1000, word address of the SPI reader buffer word 0.
- CHUNK_WORDS, 16, words fetched per flash page. Range 1..16.
- OUT_AW, 10, output write-port address width.
- TIMEOUT, 1023, cycles allowed per bus transaction (ack wait) and per busy poll sequence.

Ports:
- clk_i in 1: clock.
- rst_i in 1: asynchronous active-high reset.
- start_i in 1: start pulse; ignored while busy_o=1.
- page_i in 16: first flash page index, written to READ_ADDR.
- words_i in 16: total words to copy; 0 means done immediately.
- out_base_i in OUT_AW: first output address.
- busy_o out 1: operation in progress.
- done_o out 1: one-cycle pulse at completion.
- err_o out 1: sticky timeout flag; cleared by the next accepted start.
- m_adr_o out 16: master address.
- m_dat_o out 32: master write data.
- m_dat_i in 32: master read data.
- m_we_o out 1: master write enable.
- m_sel_o out 4: byte selects; always 4'hF.
- m_stb_o out 1: master strobe.
- m_cyc_o out 1: master cycle.
- m_ack_i in 1: master acknowledge.
- m_cti_o out 3: cycle type; always 3'b000.
- out_adr_o out OUT_AW: sink address.
- out_dat_o out 32: sink data.
- out_we_o out 1: sink write strobe.
- out_ready_i in 1: sink can accept.

Behaviour:
- Reset (async, rst_i high): every output is 0 except m_sel_o=4'hF. State returns to IDLE. All counters clear.
- Bus transactions are single classic cycles:
  - cyc/stb rise together, with adr/dat/we stable, and are held until m_ack_i.
  - They drop the cycle after ack; no back-to-back stb without a one-cycle gap.
  - Read data is captured on the ack cycle.
- State machine:
  - IDLE: on start_i, latch page_i, words_i and out_base_i; set remaining=words_i; clear err_o. Go to SET_ADDR, or DONE if words_i=0.
  - SET_ADDR: write page to SPI_BASE+SPIMEM_READ_ADDR.
  - SET_LEN: write n=min(remaining, CHUNK_WORDS) to SPI_BASE+SPIMEM_READ_LENGTH.
  - KICK: write 1 to SPI_BASE+SPIMEM_CONTROL.
  - POLL: read SPIMEM_CONTROL repeatedly; go to FETCH when bit0=0.
  - FETCH: read SPI_MEM_BASE+i, i=0..n-1.
  - PUSH: hold out_we_o=1 with out_adr_o/out_dat_o until a cycle where out_ready_i=1. That cycle is the transfer; then increment the output address and i.
  - After PUSH with i=n: remaining-=n, page+=1. Go to SET_ADDR if remaining>0, else DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE; it is 0 in the cycle done_o is high.
- Output address wraps modulo 2^OUT_AW. Page index wraps modulo 2^16.
- Timeout:
  - A per-transaction counter resets on each new transaction.
  - POLL uses one counter for the whole poll sequence.
  - When the counter reaches TIMEOUT: drop cyc/stb, set err_o=1, pulse done_o, return to IDLE.
- start_i while busy is ignored. A simultaneous start_i and done are ignored; the start must be re-issued.
- Reset mid-transaction drops cyc/stb asynchronously.

Optional Feature:
- Macro: SPI_FRAME_LOADER_CHECKSUM_EN.
- Enabled:
  - Adds output checksum_o[31:0]: a 32-bit wrapping sum of every word transferred on the sink port.
  - Cleared when a start is accepted; final value is valid when done_o pulses.
- Disabled: port is absent and no adder is synthesised.

Test Plan:
- Single partial chunk:
  - Stimulus: page_i=16'h0042, words_i=5, out_base_i=0, fake SPI slave with 1-cycle ack.
  - Required: writes READ_ADDR=0x42, READ_LENGTH=5, CONTROL=1, then polls.
  - Required: sink sees addresses 0..4 with buffer words, then done_o pulses once with err_o=0.
- Multi-chunk:
  - Stimulus: words_i=40, CHUNK_WORDS=16.
  - Required: chunks of 16/16/8, page indices 0x42/0x43/0x44, out addresses 0..39 contiguous.
- Backpressure:
  - Stimulus: out_ready_i toggling 1-in-3.
  - Required: out_we_o and data held stable until ready; no word lost or duplicated.
- Timeout:
  - Stimulus: slave never acks the READ_LENGTH write.
  - Required: after TIMEOUT cycles cyc drops, err_o=1, done_o pulses.
  - Required: next start clears err_o.
- Zero and busy start:
  - Stimulus: words_i=0.
  - Required: no bus cycle, done_o one cycle after start.
  - Stimulus: start_i pulsed mid-operation.
  - Required: no effect.
- Async reset:
  - Stimulus: rst_i asserted during FETCH with stb high.
  - Required: m_cyc_o, m_stb_o, busy_o are 0 immediately, without waiting for a clock edge.
